// File: rtl/intmatmul_pkg.sv
// Shared constants and FSM encoding for the intmatmul host-side bus sequencer.
package intmatmul_pkg;

    localparam int GlobalAddrWidth = 15;
    localparam int GlobalDataWidth = 32;

    localparam logic [GlobalAddrWidth-1:0] ADDR_MATRIX = 15'd0;
    localparam logic [GlobalAddrWidth-1:0] ADDR_VECTOR = 15'd1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_M    = 3'd1,
        LOAD_V    = 3'd2,
        WAIT      = 3'd3,
        RD_LATCH  = 3'd4,
        RD_SAMPLE = 3'd5,
        OUT       = 3'd6,
        DONE      = 3'd7
    } state_e;

endpackage

// File: rtl/intmatmul_host_seq.sv
// Bus initiator: scan-writes matrix and vector words into the intmatmul slave,
// waits for the dot products, then reads the results back as a valid/ready stream.
module intmatmul_host_seq
    import intmatmul_pkg::*;
#(
    parameter int pVectorSize  = 8,
    parameter int pWordSize    = 8,
    parameter int pComputeWait = 2
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [pWordSize-1:0]       in_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [pWordSize-1:0]       res_data,
    output logic                       res_last,
    output logic                       RD,
    output logic                       WR,
    output logic [GlobalAddrWidth-1:0] Addr,
    output logic [GlobalDataWidth-1:0] DataOut,
    input  logic [GlobalDataWidth-1:0] DataIn
);

    localparam int CNT_W = 16;
    localparam int K_W   = (pVectorSize > 1) ? $clog2(pVectorSize) : 1;

    localparam logic [CNT_W-1:0] MAT_LAST  = CNT_W'(pVectorSize * pVectorSize - 1);
    localparam logic [CNT_W-1:0] VEC_LAST  = CNT_W'(pVectorSize - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(pComputeWait);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [K_W-1:0]   K_LAST    = K_W'(pVectorSize - 1);
    localparam logic [K_W-1:0]   K_ONE     = K_W'(1);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           wc_q, wc_d;
    logic [K_W-1:0]             k_q, k_d;

    logic                       rd_q, rd_d;
    logic                       wr_q, wr_d;
    logic [GlobalAddrWidth-1:0] addr_q, addr_d;
    logic [GlobalDataWidth-1:0] dout_q, dout_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       in_ready_q, in_ready_d;
    logic                       res_valid_q, res_valid_d;
    logic [pWordSize-1:0]       res_data_q, res_data_d;
    logic                       res_last_q, res_last_d;

    logic                       in_hs_s;
    logic                       unused_datain_s;

    // The handshake is qualified by the registered in_ready the source actually saw.
    assign in_hs_s         = in_valid & in_ready_q;
    assign unused_datain_s = ^DataIn;

    // State and counter registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            wc_q    <= {CNT_W{1'b0}};
            k_q     <= {K_W{1'b0}};
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            k_q     <= k_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_M;
                    wc_d    = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_M: begin
                if (in_hs_s && (wc_q == MAT_LAST)) begin
                    state_d = LOAD_V;
                    wc_d    = {CNT_W{1'b0}};
                end else if (in_hs_s) begin
                    wc_d = wc_q + CNT_ONE;
                end else begin
                    wc_d = wc_q;
                end
            end
            LOAD_V: begin
                if (in_hs_s && (wc_q == VEC_LAST)) begin
                    state_d = WAIT;
                    wc_d    = {CNT_W{1'b0}};
                end else if (in_hs_s) begin
                    wc_d = wc_q + CNT_ONE;
                end else begin
                    wc_d = wc_q;
                end
            end
            WAIT: begin
                // First WAIT cycle carries the final WR, so the gap to RD is pComputeWait idle cycles.
                if (wc_q == WAIT_LAST) begin
                    state_d = RD_LATCH;
                    wc_d    = {CNT_W{1'b0}};
                    k_d     = {K_W{1'b0}};
                end else begin
                    wc_d = wc_q + CNT_ONE;
                end
            end
            RD_LATCH:  state_d = RD_SAMPLE;
            RD_SAMPLE: state_d = OUT;
            OUT: begin
                if (res_ready && (k_q == K_LAST)) begin
                    state_d = DONE;
                end else if (res_ready) begin
                    state_d = RD_LATCH;
                    k_d     = k_q + K_ONE;
                end else begin
                    state_d = OUT;
                end
            end
            DONE: begin
                state_d = IDLE;
                wc_d    = {CNT_W{1'b0}};
                k_d     = {K_W{1'b0}};
            end
            default: begin
                state_d = IDLE;
                wc_d    = {CNT_W{1'b0}};
                k_d     = {K_W{1'b0}};
            end
        endcase
    end

    // Output decode: computed from the next state so every output leaves a flop aligned with state_q.
    always_comb begin
        rd_d        = (state_d == RD_LATCH) || (state_d == RD_SAMPLE);
        wr_d        = in_hs_s;
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        res_valid_d = (state_d == OUT);
        res_last_d  = (state_d == OUT) && (k_d == K_LAST);
        in_ready_d  = ((state_d == LOAD_M) || (state_d == LOAD_V)) &&
                      !((state_q == LOAD_M) && (state_d == LOAD_V));
        if (rd_d) begin
            addr_d = GlobalAddrWidth'(k_d);
        end else if (in_hs_s && (state_q == LOAD_V)) begin
            addr_d = ADDR_VECTOR;
        end else begin
            addr_d = ADDR_MATRIX;
        end
        if (in_hs_s) begin
            dout_d = GlobalDataWidth'(in_data);
        end else begin
            dout_d = {GlobalDataWidth{1'b0}};
        end
        if (state_q == RD_SAMPLE) begin
            res_data_d = DataIn[pWordSize-1:0];
        end else begin
            res_data_d = res_data_q;
        end
    end

    // Output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= {GlobalAddrWidth{1'b0}};
            dout_q      <= {GlobalDataWidth{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= {pWordSize{1'b0}};
            res_last_q  <= 1'b0;
        end else begin
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
        end
    end

    assign RD        = rd_q;
    assign WR        = wr_q;
    assign Addr      = addr_q;
    assign DataOut   = dout_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_last  = res_last_q;

endmodule

// File: tb/tb_intmatmul_host_seq.sv
// Self-checking bench for intmatmul_host_seq with a behavioural scan-mode slave attached.
module tb_intmatmul_host_seq;
    import intmatmul_pkg::*;

    localparam int VS    = 8;
    localparam int WS    = 8;
    localparam int CWAIT = 2;
    localparam int NMAT  = VS * VS;
    localparam int NW    = NMAT + VS;

    typedef struct packed {
        logic [NMAT-1:0][WS-1:0] mat;
        logic [VS-1:0][WS-1:0]   vec;
        logic [VS-1:0][WS-1:0]   exp;
        logic                    gappy;
        int                      stall_k;
        int                      abort_at;
        int                      busy_start_at;
    } tv_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [WS-1:0] in_data = '0;
    logic        res_ready = 1'b1;
    logic [31:0] DataIn;
    logic        busy, done, in_ready, res_valid, res_last, RD, WR;
    logic [WS-1:0] res_data;
    logic [14:0] Addr;
    logic [31:0] DataOut;

    intmatmul_host_seq #(.pVectorSize(VS), .pWordSize(WS), .pComputeWait(CWAIT)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .RD(RD), .WR(WR), .Addr(Addr), .DataOut(DataOut), .DataIn(DataIn)
    );

    always #5 Clk = ~Clk;

    // Slave model: scan-shifts writes, latches the addressed dot product on the first RD cycle.
    logic [WS-1:0] sm [NMAT];
    logic [WS-1:0] sv [VS];
    int            mi = 0;
    int            vi = 0;
    logic          rd_prev = 1'b0;
    logic [WS-1:0] holder = '0;

    function automatic logic [WS-1:0] slave_dot(input int a);
        logic [WS-1:0] s = '0;
        if (a < VS) begin
            for (int j = 0; j < VS; j++) s = s + WS'(sm[a*VS+j] * sv[j]);
        end
        return s;
    endfunction

    always @(negedge Clk) begin
        if (!Reset_n || !busy) begin
            mi = 0; vi = 0; rd_prev = 1'b0;
        end else begin
            if (WR) begin
                if (Addr == 15'd0) begin
                    if (mi < NMAT) sm[mi] = DataOut[WS-1:0];
                    mi++;
                end else begin
                    if (vi < VS) sv[vi] = DataOut[WS-1:0];
                    vi++;
                end
            end
            if (RD && !rd_prev) holder = slave_dot(int'(Addr));
            rd_prev = RD;
        end
    end

    assign DataIn = {24'hA5A5A5, holder};

    // Bench state: everything below is owned by the single initial process.
    int n_pass = 0, n_total = 0;
    int cyc = 0, last_wr_cyc = 0;
    int wr0_cnt, wr1_cnt, res_cnt, done_cnt, inv_err, stall_cyc;
    logic rd_seen, done_seen, hs_prev, prev_stall;
    logic [WS-1:0] din_prev, prev_res, exp_r;
    logic [WS-1:0] sb [$];
    tv_t tv [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    function automatic logic [WS-1:0] dotp(input tv_t t, input int k);
        logic [WS-1:0] s = '0;
        for (int j = 0; j < VS; j++) s = s + WS'(t.mat[k*VS+j] * t.vec[j]);
        return s;
    endfunction

    // Record this cycle's handshakes, then advance to the middle of the next cycle and monitor it.
    task automatic tick();
        if (Reset_n) begin
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    inv_err++;
                end else begin
                    exp_r = sb.pop_front();
                    chk("res_data", 32'(res_data), 32'(exp_r));
                    chk("res_last", 32'(res_last), 32'(res_cnt == VS - 1));
                    res_cnt++;
                end
            end
            if (res_valid && !res_ready) stall_cyc++;
            prev_stall = res_valid && !res_ready;
            prev_res   = res_data;
            hs_prev    = in_valid && in_ready;
            din_prev   = in_data;
        end else begin
            hs_prev = 1'b0; prev_stall = 1'b0;
        end
        @(negedge Clk);
        cyc++;
        if (Reset_n) begin
            if (WR !== hs_prev) inv_err++;
            if (WR) begin
                chk("wr_addr", 32'(Addr), (wr0_cnt + wr1_cnt < NMAT) ? 32'd0 : 32'd1);
                chk("wr_data", DataOut, {24'h0, din_prev});
                if (Addr == 15'd0) wr0_cnt++; else wr1_cnt++;
                last_wr_cyc = cyc;
            end
            if (RD && WR) inv_err++;
            if (!RD && !WR && Addr != 15'd0) inv_err++;
            if (RD && !rd_seen) begin
                rd_seen = 1'b1;
                chk("first_rd_gap", 32'(cyc - last_wr_cyc), 32'(CWAIT + 1));
            end
            if (!res_valid && res_last) inv_err++;
            if (prev_stall && (!res_valid || res_data !== prev_res || RD || Addr != 15'd0)) inv_err++;
            if (done) begin done_cnt++; done_seen = 1'b1; end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, 32'({busy, done, in_ready, res_valid, res_last}), 32'd0);
        chk({tag, "_bus"}, 32'({RD, WR, Addr}), 32'd0);
        chk({tag, "_dout"}, DataOut, 32'd0);
        chk({tag, "_res_data"}, 32'(res_data), 32'd0);
    endtask

    task automatic run_test(input tv_t t);
        logic got;
        int   stall_left;
        wr0_cnt = 0; wr1_cnt = 0; res_cnt = 0; done_cnt = 0; inv_err = 0; stall_cyc = 0;
        rd_seen = 1'b0; done_seen = 1'b0;
        for (int k = 0; k < VS; k++) sb.push_back(t.exp[k]);
        start = 1'b1; tick(); start = 1'b0;
        for (int w = 0; w < NW; w++) begin
            if (w == t.abort_at) begin
                in_valid = 1'b0;
                chk("pre_reset_busy", 32'(busy), 32'd1);
                #2 Reset_n = 1'b0;
                #1 check_zero("async_reset");
                tick(); tick();
                Reset_n = 1'b1;
                tick();
                chk("post_reset_idle", 32'({busy, RD, WR, in_ready}), 32'd0);
                sb.delete();
                return;
            end
            in_valid = 1'b1;
            in_data  = (w < NMAT) ? t.mat[w] : t.vec[w-NMAT];
            if (w == t.busy_start_at) start = 1'b1;
            got = 1'b0;
            for (int n = 0; n < 20; n++) begin
                got = in_ready;
                tick();
                start = 1'b0;
                if (got) break;
            end
            if (!got) begin
                chk("in_ready_timeout", 32'(got), 32'd1);
                in_valid = 1'b0; sb.delete();
                return;
            end
            if (t.gappy) begin in_valid = 1'b0; tick(); end
        end
        in_valid = 1'b0;
        stall_left = 5;
        for (int n = 0; n < 400 && !done_seen; n++) begin
            if (res_valid && res_cnt == t.stall_k && stall_left > 0) begin
                res_ready = 1'b0; stall_left--;
            end else begin
                res_ready = 1'b1;
            end
            tick();
        end
        res_ready = 1'b1;
        tick(); tick();
        chk("done_seen", 32'(done_seen), 32'd1);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("wr_matrix_count", 32'(wr0_cnt), 32'(NMAT));
        chk("wr_vector_count", 32'(wr1_cnt), 32'(VS));
        chk("result_count", 32'(res_cnt), 32'(VS));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("invariants", 32'(inv_err), 32'd0);
        chk("stall_cycles", 32'(stall_cyc), (t.stall_k >= 0) ? 32'd5 : 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
        sb.delete();
    endtask

    initial begin
        for (int i = 0; i < 7; i++) begin
            tv[i] = '0;
            tv[i].stall_k = -1; tv[i].abort_at = -1; tv[i].busy_start_at = -1;
        end
        for (int i = 0; i < NMAT; i++) begin
            tv[0].mat[i] = (i / VS == i % VS) ? 8'd1 : 8'd0;
            tv[1].mat[i] = 8'd2;
            tv[2].mat[i] = 8'd16;
            tv[3].mat[i] = 8'(i * 7 + 3);
            tv[4].mat[i] = 8'(i);
            tv[5].mat[i] = tv[0].mat[i];
            tv[6].mat[i] = 8'(255 - i);
        end
        for (int j = 0; j < VS; j++) begin
            tv[0].vec[j] = 8'(j + 1); tv[0].exp[j] = 8'(j + 1);
            tv[1].vec[j] = 8'd3;      tv[1].exp[j] = 8'd48;
            tv[2].vec[j] = 8'd16;     tv[2].exp[j] = 8'd0;
            tv[3].vec[j] = 8'(j + 5);
            tv[4].vec[j] = 8'd1;
            tv[5].vec[j] = 8'(j + 1);
            tv[6].vec[j] = 8'(2 * j + 1);
        end
        tv[3].gappy = 1'b1;
        tv[4].stall_k = 3;
        tv[5].abort_at = NMAT + 4;
        tv[6].busy_start_at = 10;
        for (int i = 3; i < 7; i++)
            for (int k = 0; k < VS; k++) tv[i].exp[k] = dotp(tv[i], k);

        tick(); tick(); tick();
        check_zero("reset");
        Reset_n = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) run_test(tv[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/intmatmul_host_seq.md
Name: intmatmul_host_seq

Overview:
- Bus-initiator sequencer that drives the global RD/WR/Addr/Data bus of the scan-mode integer matrix-multiply unit.
- Accepts a stream of matrix and vector words, scan-writes them into the unit, waits for the dot products, and reads back the pVectorSize results.
- Emits the results as a valid/ready stream.
- Sits between a host-side word source/sink and the intmatmul slave.

Parameters:
- pVectorSize, 8, vector length; the matrix is pVectorSize x pVectorSize.
- pWordSize, 8, element and result width in bits (<= 32).
- pComputeWait, 2, idle bus cycles between the final vector WR cycle and the first RD cycle; legal range >= 1.

Ports:
- Clk  in  1  clock; everything is on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a multiply; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result has been accepted.
- in_valid  in  1  source word valid.
- in_ready  out  1  high only in LOAD_M and LOAD_V.
- in_data  in  pWordSize  matrix words (row-major, element 0 first), then vector words (element 0 first).
- res_valid  out  1  result word valid.
- res_ready  in  1  sink ready.
- res_data  out  pWordSize  result k = row k dot vector, truncated mod 2^pWordSize by the slave.
- res_last  out  1  high with result pVectorSize-1.
- RD  out  1  bus read strobe.
- WR  out  1  bus write strobe.
- Addr  out  15  bus address (GlobalAddrWidth).
- DataOut  out  32  bus write data; in_data zero-extended.
- DataIn  in  32  bus read data; bits [pWordSize-1:0] are used.

Behaviour:
- Reset (asynchronous, Reset_n=0): state IDLE. All outputs are 0: RD, WR, Addr, DataOut, busy, done, in_ready, res_valid, res_data, res_last. All counters clear. Reset mid-operation abandons the transaction; no partial bus cycle completes after reset deasserts.
- All bus outputs come from flops.
- IDLE: when start=1, go to LOAD_M and clear word counter wc. If start arrives while busy it is ignored.
- LOAD_M:
  - in_ready=1. A handshake (in_valid & in_ready) at cycle t produces WR=1, Addr=0, DataOut=in_data at cycle t+1, for exactly one cycle.
  - No handshake means WR=0 in the next cycle. Gaps in in_valid are legal; back-to-back writes are legal.
  - After the pVectorSize^2-th handshake, go to LOAD_V, clear wc, and hold in_ready low for that transition cycle.
- LOAD_V: same as LOAD_M but with Addr=1 and pVectorSize words. After the last handshake, go to WAIT.
- WAIT: count pComputeWait cycles after the cycle carrying the final WR. RD=WR=0 throughout. Then set k=0 and go to RD_LATCH.
- RD_LATCH: RD=1, Addr=k for one cycle; the slave latches its holder register on this cycle.
- RD_SAMPLE: RD=1, Addr=k. Capture DataIn[pWordSize-1:0] into res_data at the end of this cycle, then go to OUT.
- OUT:
  - res_valid=1, res_last=(k==pVectorSize-1). RD=0, and res_data is held stable while res_ready=0.
  - On res_ready=1: drop res_valid. If k<pVectorSize-1, increment k and go to RD_LATCH. Otherwise go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- RD and WR are never high in the same cycle.
- Addr takes only values 0, 1, and 0..pVectorSize-1. It returns to 0 when RD=WR=0.
- Throughput per result: 3 cycles minimum.

Decomposition:
- Package intmatmul_pkg:
  - ADDR_MATRIX=0 and ADDR_VECTOR=1.
  - State enumeration: IDLE, LOAD_M, LOAD_V, WAIT, RD_LATCH, RD_SAMPLE, OUT, DONE.
  - A GlobalAddrWidth/GlobalDataWidth mirror.
- No sub-module; a single FSM with two counters (wc and k).

Test Plan:
1. Identity matrix, vector 1..8, slave model attached. Expected: exactly 64 WR at Addr 0 then 8 WR at Addr 1; results 1,2,...,8; res_last only on 8; one done pulse.
2. All matrix words = 2, all vector words = 3. Expected: all 8 results = 48.
3. All words = 16 (8*256 wraps mod 256). Expected: all results = 0. Confirms truncation and width handling.
4. in_valid toggled 1-0-1-0 during loading. Expected:
   - WR count = handshake count, each WR exactly one cycle after its handshake;
   - first RD exactly pComputeWait+1 cycles after the final WR.
5. res_ready held low for 5 cycles on result 3. Expected: res_valid and res_data stable, RD=0, Addr=0 during the stall; result 4 read proceeds after acceptance.
6. Reset_n pulsed low mid-LOAD_V (word 4). Expected:
   - outputs zero immediately, with no clock edge needed;
   - a later start performs a full 64+8-write sequence and correct results;
   - start asserted while busy is ignored.
